// File: rtl/ir_tx_block.sv
// ir_tx_block: memory-mapped NEC infrared transmitter (leader, 32 payload bits, stop mark).
// Latency: a DATA write at edge N gives busy=1 and ir_tx=1 after edge N. Status reads are combinational.
// Backpressure: none. A DATA write while busy is dropped and sets the sticky overrun flag.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   MemWrite, dir, D    bus write strobe, address, write data (D[15:8] = NEC address, D[7:0] = command)
//   rd_hit, rd_data     status read decode and data {29'b0, overrun, done, busy}
//   busy, ir_tx         frame in progress, IR LED drive
module ir_tx_block #(
    parameter logic [4:0] DATA_ADDR   = 5'd28,
    parameter logic [4:0] STATUS_ADDR = 5'd29,
    parameter int         UNIT_CYCLES = 28125,
    parameter int         CARRIER_DIV = 658,
    parameter bit         CARRIER_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [4:0]  dir,
    input  logic [31:0] D,
    output logic        rd_hit,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        ir_tx
);

    localparam int UW = $clog2(UNIT_CYCLES);
    localparam int CW = $clog2(CARRIER_DIV + 1);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEADER_MARK,
        S_LEADER_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK
    } state_t;

    state_t          state, state_nxt;
    logic [UW-1:0]   unit_cnt;
    logic [3:0]      phase_cnt;
    logic [3:0]      phase_last;
    logic [4:0]      bit_cnt;
    logic [31:0]     shreg;
    logic [CW-1:0]   car_cnt;
    logic            done, overrun;
    logic            wr_data, wr_status, start;
    logic            unit_end, phase_end, state_chg, mark_cur, mark_nxt;
    logic            unused_d;

    // The upper half of the data word carries nothing.
    assign unused_d = ^D[31:16];

    assign wr_data   = MemWrite && (dir == DATA_ADDR);
    assign wr_status = MemWrite && (dir == STATUS_ADDR);
    assign start     = wr_data && (state == S_IDLE);

    assign rd_hit  = (dir == STATUS_ADDR);
    assign rd_data = rd_hit ? {29'b0, overrun, done, busy} : 32'b0;

    assign mark_cur = (state == S_LEADER_MARK) || (state == S_BIT_MARK) || (state == S_STOP_MARK);
    assign mark_nxt = (state_nxt == S_LEADER_MARK) || (state_nxt == S_BIT_MARK) ||
                      (state_nxt == S_STOP_MARK);

    // Index of the last unit of the current phase. A '1' bit has a 3-unit space.
    always_comb begin
        phase_last = 4'd0;
        case (state)
            S_LEADER_MARK:  phase_last = 4'd15;
            S_LEADER_SPACE: phase_last = 4'd7;
            S_BIT_SPACE:    phase_last = shreg[0] ? 4'd2 : 4'd0;
            default:        phase_last = 4'd0;
        endcase
    end

    assign unit_end  = (unit_cnt == UNIT_LAST);
    assign phase_end = unit_end && (phase_cnt == phase_last);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:         if (start)     state_nxt = S_LEADER_MARK;
            S_LEADER_MARK:  if (phase_end) state_nxt = S_LEADER_SPACE;
            S_LEADER_SPACE: if (phase_end) state_nxt = S_BIT_MARK;
            S_BIT_MARK:     if (phase_end) state_nxt = S_BIT_SPACE;
            S_BIT_SPACE:    if (phase_end) state_nxt = (bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            S_STOP_MARK:    if (phase_end) state_nxt = S_IDLE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Every transition moves to a different state, so this marks each phase boundary.
    assign state_chg = (state_nxt != state);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            unit_cnt  <= '0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            car_cnt   <= '0;
            ir_tx     <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);

            if (state_chg) begin
                unit_cnt  <= '0;
                phase_cnt <= '0;
            end else if (state != S_IDLE) begin
                if (unit_end) begin
                    unit_cnt  <= '0;
                    phase_cnt <= phase_cnt + 4'd1;
                end else begin
                    unit_cnt <= unit_cnt + UW'(1);
                end
            end

            if (start) begin
                shreg   <= {~D[7:0], D[7:0], ~D[15:8], D[15:8]};
                bit_cnt <= 5'd0;
            end else if ((state == S_BIT_SPACE) && phase_end) begin
                shreg <= shreg >> 1;
                if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            end

            // Each mark starts high with a fresh carrier phase; spaces and idle are low.
            if (state_chg) begin
                ir_tx   <= mark_nxt;
                car_cnt <= '0;
            end else if (mark_cur && CARRIER_EN) begin
                if (car_cnt == CAR_LAST) begin
                    ir_tx   <= ~ir_tx;
                    car_cnt <= '0;
                end else begin
                    car_cnt <= car_cnt + CW'(1);
                end
            end

            // Flag sets take priority over a status-write clear on the same edge.
            if ((state == S_STOP_MARK) && phase_end) done <= 1'b1;
            else if (wr_status || start)             done <= 1'b0;

            if (wr_data && (state != S_IDLE)) overrun <= 1'b1;
            else if (wr_status)               overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ir_tx_block.sv
// tb_ir_tx_block: scoreboard bench for ir_tx_block with an envelope instance and a carrier instance.
// Latency: frames are decoded from mark/space run lengths and compared against a queued model.
// Backpressure: not applicable; a shared bus drives both instances.
module tb_ir_tx_block;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [4:0]  dir;
    logic [31:0] D;
    logic        rd_hit_a, rd_hit_b, busy_a, busy_b, ir_tx_a, ir_tx_b;
    logic [31:0] rd_data_a, rd_data_b;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] payload;
        int          len;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ir_tx_block #(.UNIT_CYCLES(4), .CARRIER_DIV(1), .CARRIER_EN(1'b0)) u_env (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .dir(dir), .D(D),
        .rd_hit(rd_hit_a), .rd_data(rd_data_a), .busy(busy_a), .ir_tx(ir_tx_a)
    );

    ir_tx_block #(.UNIT_CYCLES(4), .CARRIER_DIV(2), .CARRIER_EN(1'b1)) u_car (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .dir(dir), .D(D),
        .rd_hit(rd_hit_b), .rd_data(rd_data_b), .busy(busy_b), .ir_tx(ir_tx_b)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic read_status(input string tag, input logic [31:0] exp);
        MemWrite = 1'b0;
        dir      = 5'd29;
        #1;
        check_val(tag, rd_data_a, exp);
    endtask

    task automatic write_status();
        MemWrite = 1'b1;
        dir      = 5'd29;
        D        = 32'hFFFF_FFFF;
        @(negedge clk);
        MemWrite = 1'b0;
        dir      = 5'd0;
        D        = 32'h0;
    endtask

    // Called at a negedge. inj >= 0 injects a DATA write at that sample and exercises status
    // reads/clears around it; inj == -2 injects on the last busy cycle; -1 injects nothing.
    task automatic run_frame(input logic [15:0] d, input int inj);
        exp_t       e;
        logic       samp[$];
        int         runs[$];
        int         k, inj_k, cur, lead_bad, sp_bad, ms_bad, mark_bad;
        logic       prev_a, timeout;
        logic [31:0] dec;

        e.payload = {~d[7:0], d[7:0], ~d[15:8], d[15:8]};
        e.len     = 4 * (24 + 64 + 2 * $countones(e.payload) + 1);
        exp_q.push_back(e);
        inj_k = (inj == -2) ? e.len - 1 : inj;

        MemWrite = 1'b1;
        dir      = 5'd28;
        D        = {16'hDEAD, d};
        k = 0; timeout = 1'b0; prev_a = 1'b0;
        lead_bad = 0; sp_bad = 0; ms_bad = 0;
        while (1) begin
            @(negedge clk);
            MemWrite = 1'b0;
            dir      = 5'd0;
            D        = 32'h0;
            if (!busy_a) break;
            if (k >= 2000) begin
                timeout = 1'b1;
                break;
            end
            samp.push_back(ir_tx_a);
            if (k < 64 && ir_tx_b !== ((k % 4) < 2)) lead_bad++;
            if (ir_tx_a == 1'b0 && ir_tx_b !== 1'b0) sp_bad++;
            if (ir_tx_a == 1'b1 && prev_a == 1'b0 && ir_tx_b !== 1'b1) ms_bad++;
            prev_a = ir_tx_a;
            if (k == inj_k) begin
                MemWrite = 1'b1;
                dir      = 5'd28;
                D        = 32'h0000_ABCD;
            end
            if (inj_k >= 0) begin
                if (k == inj_k + 1) read_status("ovr_busy_status", 32'h5);
                if (k == inj_k + 2) begin
                    MemWrite = 1'b1;
                    dir      = 5'd29;
                end
                if (k == inj_k + 3) read_status("ovr_cleared_status", 32'h1);
            end
            k++;
        end

        check_val("timeout", {31'b0, timeout}, 32'h0);
        e = exp_q.pop_front();
        check_val("busy_len", k, e.len);
        check_val("busy_b_end", {31'b0, busy_b}, 32'h0);
        check_val("carrier_leader", lead_bad, 0);
        check_val("carrier_space", sp_bad, 0);
        check_val("carrier_mark_start", ms_bad, 0);

        cur = 1;
        for (int i = 1; i < samp.size(); i++) begin
            if (samp[i] == samp[i-1]) cur++;
            else begin
                runs.push_back(cur);
                cur = 1;
            end
        end
        if (samp.size() > 0) begin
            runs.push_back(cur);
            check_val("first_tx", {31'b0, samp[0]}, 32'h1);
        end
        check_val("run_count", runs.size(), 67);
        if (runs.size() == 67) begin
            check_val("leader_mark", runs[0], 64);
            check_val("leader_space", runs[1], 32);
            check_val("bit0_mark", runs[2], 4);
            check_val("stop_mark", runs[66], 4);
            mark_bad = 0;
            dec = 32'h0;
            for (int i = 0; i < 32; i++) begin
                if (runs[2 + 2*i] != 4) mark_bad++;
                dec[i] = (runs[3 + 2*i] > 8);
            end
            check_val("bit_marks", mark_bad, 0);
            check_val("payload", dec, e.payload);
        end
    endtask

    initial begin
        reset    = 1'b1;
        MemWrite = 1'b0;
        dir      = 5'd0;
        D        = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        check_val("idle_busy", {31'b0, busy_a}, 32'h0);
        check_val("idle_tx_env", {31'b0, ir_tx_a}, 32'h0);
        check_val("idle_tx_car", {31'b0, ir_tx_b}, 32'h0);
        read_status("idle_status", 32'h0);
        check_val("idle_rd_hit", {31'b0, rd_hit_a}, 32'h1);
        dir = 5'd5;
        #1;
        check_val("other_rd_hit", {31'b0, rd_hit_a}, 32'h0);
        check_val("other_rd_data", rd_data_a, 32'h0);
        @(negedge clk);

        run_frame(16'h0000, -1);
        read_status("done_status", 32'h2);
        @(negedge clk);
        write_status();
        read_status("cleared_status", 32'h0);
        @(negedge clk);

        run_frame(16'h00FF, -1);
        read_status("done_status_ff", 32'h2);
        @(negedge clk);

        run_frame(16'h1234, 100);
        read_status("after_overrun_status", 32'h2);
        @(negedge clk);

        run_frame(16'hC3A1, -2);
        run_frame(16'h5A3C, -1);
        read_status("back_to_back_status", 32'h6);
        @(negedge clk);

        // Reset partway into bit 10 of an all-zero frame (leader 96 cycles + 10 bits of 8).
        MemWrite = 1'b1;
        dir      = 5'd28;
        D        = 32'h0;
        @(negedge clk);
        MemWrite = 1'b0;
        dir      = 5'd0;
        repeat (180) @(negedge clk);
        check_val("pre_reset_busy", {31'b0, busy_a}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("reset_tx", {31'b0, ir_tx_a}, 32'h0);
        check_val("reset_busy", {31'b0, busy_a}, 32'h0);
        check_val("reset_tx_car", {31'b0, ir_tx_b}, 32'h0);
        read_status("reset_status", 32'h0);
        @(negedge clk);

        run_frame(16'hA55A, -1);
        read_status("post_reset_done", 32'h2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
